// File: rtl/cordic_fm_discr.sv
// cordic_fm_discr
// Frequency discriminator sitting behind a fixed-latency CORDIC atan/magnitude
// stage. The input sample strobe is delayed to line up with the CORDIC outputs,
// successive valid angles are differenced (modulo 2^32, so +/-180 degree
// crossings unwrap for free) and the differences are accumulated and dumped
// once per 2^DECIM_LOG2 valid samples as a floor-averaged frequency word.
//
// Build option: define CORDIC_FM_SQUELCH_EN to enable the magnitude squelch.
// With it, samples whose radius is below sq_level contribute a zero difference
// and flag the block on the squelch output. Without it, sq_level/coe_radius are
// ignored and squelch is tied low.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   in_valid    in   sample strobe at the CORDIC input
//   angle       in   [31:0] signed CORDIC angle, +/-2^31 = +/-180 deg
//   coe_radius  in   [31:0] unsigned CORDIC radius
//   sq_level    in   [31:0] unsigned squelch threshold
//   freq        out  [31:0] signed decimated phase-difference average
//   freq_valid  out  one-cycle pulse per output block
//   squelch     out  block contained at least one squelched sample
module cordic_fm_discr #(
    parameter int LATENCY    = 32,
    parameter int DECIM_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] angle,
    input  logic [31:0] coe_radius,
    input  logic [31:0] sq_level,
    output logic [31:0] freq,
    output logic        freq_valid,
    output logic        squelch
);

    localparam int AW = 32 + DECIM_LOG2;
    localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CW-1:0] DUMP_CNT = CW'((1 << DECIM_LOG2) - 1);

    typedef enum logic {PRIME, RUN} state_t;

    // Floor average: arithmetic shift of the block sum, keep the low 32 bits.
    function automatic logic [31:0] avg_floor(input logic signed [AW-1:0] s);
        return 32'(s >>> DECIM_LOG2);
    endfunction

    logic [LATENCY-1:0]   vdly_q, vdly_d;
    state_t               state_q, state_d;
    logic [31:0]          prev_q, prev_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          freq_q, freq_d;
    logic                 fvalid_q, fvalid_d;

    logic                 v_al;
    logic signed [31:0]   diff;
    logic signed [31:0]   d_use;
    logic signed [AW-1:0] sum;

`ifdef CORDIC_FM_SQUELCH_EN
    logic sq_seen_q, sq_seen_d;
    logic squelch_q, squelch_d;
    logic sq_cur;

    assign sq_cur  = (coe_radius < sq_level);
    assign squelch = squelch_q;
`else
    logic unused_sq;

    assign unused_sq = ^{coe_radius, sq_level};
    assign squelch   = 1'b0;
`endif

    assign v_al       = vdly_q[LATENCY-1];
    assign freq       = freq_q;
    assign freq_valid = fvalid_q;

    always_comb begin
        // Shift form works for any LATENCY >= 1.
        vdly_d   = (vdly_q << 1) | LATENCY'(in_valid);
        state_d  = state_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        freq_d   = freq_q;
        fvalid_d = 1'b0;
        // Modulo-2^32 difference: wrap across +/-180 deg gives the short way round.
        diff     = $signed(angle - prev_q);
`ifdef CORDIC_FM_SQUELCH_EN
        sq_seen_d = sq_seen_q;
        squelch_d = squelch_q;
        d_use     = sq_cur ? 32'sd0 : diff;
`else
        d_use     = diff;
`endif
        sum = acc_q + AW'(d_use);

        if (v_al) begin
            // prev_angle always tracks the real angle, squelched or not.
            prev_d = angle;
            if (state_q == PRIME) begin
                state_d = RUN;
            end else if (cnt_q == DUMP_CNT) begin
                freq_d   = avg_floor(sum);
                fvalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
`ifdef CORDIC_FM_SQUELCH_EN
                squelch_d = sq_seen_q | sq_cur;
                sq_seen_d = 1'b0;
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
`ifdef CORDIC_FM_SQUELCH_EN
                sq_seen_d = sq_seen_q | sq_cur;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vdly_q   <= '0;
            state_q  <= PRIME;
            prev_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            freq_q   <= '0;
            fvalid_q <= 1'b0;
`ifdef CORDIC_FM_SQUELCH_EN
            sq_seen_q <= 1'b0;
            squelch_q <= 1'b0;
`endif
        end else begin
            vdly_q   <= vdly_d;
            state_q  <= state_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            freq_q   <= freq_d;
            fvalid_q <= fvalid_d;
`ifdef CORDIC_FM_SQUELCH_EN
            sq_seen_q <= sq_seen_d;
            squelch_q <= squelch_d;
`endif
        end
    end

endmodule

// File: tb/tb_cordic_fm_discr.sv
// Bench for cordic_fm_discr: three instances (DECIM_LOG2 = 3, 0, 1) share one
// stimulus stream fed through a stand-in CORDIC delay line of LATENCY stages.
// A reference model per instance pushes expected words (with due cycle) to a
// scoreboard queue when a sample is driven; the monitor pops on freq_valid.
module tb_cordic_fm_discr;

    localparam int LAT = 32;
    localparam int NI  = 3;
    localparam int DLS [NI] = '{3, 0, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a_src = '0;
    logic [31:0] r_src = '0;
    logic [31:0] sq_lvl = 32'h0000_1000;
    logic [31:0] angle, coe_radius;
    logic [31:0] pa [LAT];
    logic [31:0] pr [LAT];

    logic [NI-1:0]       fv_w, sq_w;
    logic [NI-1:0][31:0] fr_w;

    typedef struct {
        longint      due;
        logic [31:0] f;
        logic        s;
    } exp_t;

    exp_t        sb [NI][$];
    bit          hp  [NI];
    logic [31:0] pv  [NI];
    longint      acc [NI];
    int          cnt [NI];
    bit          sqs [NI];

    longint cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in CORDIC: pure LAT-cycle delay on angle and radius.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pa[0] <= a_src;
        pr[0] <= r_src;
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pr[i] <= pr[i-1];
        end
    end
    assign angle      = pa[LAT-1];
    assign coe_radius = pr[LAT-1];

    cordic_fm_discr #(.LATENCY(LAT), .DECIM_LOG2(3)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .angle(angle),
        .coe_radius(coe_radius), .sq_level(sq_lvl),
        .freq(fr_w[0]), .freq_valid(fv_w[0]), .squelch(sq_w[0]));

    cordic_fm_discr #(.LATENCY(LAT), .DECIM_LOG2(0)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .angle(angle),
        .coe_radius(coe_radius), .sq_level(sq_lvl),
        .freq(fr_w[1]), .freq_valid(fv_w[1]), .squelch(sq_w[1]));

    cordic_fm_discr #(.LATENCY(LAT), .DECIM_LOG2(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .angle(angle),
        .coe_radius(coe_radius), .sq_level(sq_lvl),
        .freq(fr_w[2]), .freq_valid(fv_w[2]), .squelch(sq_w[2]));

    task automatic chk(input string tag, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            hp[k] = 0; pv[k] = '0; acc[k] = 0; cnt[k] = 0; sqs[k] = 0;
            sb[k].delete();
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] r);
        for (int k = 0; k < NI; k++) begin
            bit          sc;
            logic [31:0] d;
            longint      ds;
            exp_t        e;
            sc = 0;
`ifdef CORDIC_FM_SQUELCH_EN
            sc = (r < sq_lvl);
`endif
            if (!hp[k]) begin
                hp[k] = 1;
                pv[k] = a;
            end else begin
                d     = a - pv[k];
                pv[k] = a;
                ds    = sc ? 0 : longint'($signed(d));
                if (cnt[k] == (1 << DLS[k]) - 1) begin
                    e.due = cyc + 1 + LAT;
                    e.f   = 32'((acc[k] + ds) >>> DLS[k]);
                    e.s   = sqs[k] | sc;
                    sb[k].push_back(e);
                    acc[k] = 0; cnt[k] = 0; sqs[k] = 0;
                end else begin
                    acc[k] += ds;
                    cnt[k]++;
                    sqs[k] |= sc;
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] r);
        @(negedge clk);
        in_valid = 1'b1;
        a_src    = a;
        r_src    = r;
        model(a, r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        model_clear();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_freq%0d", k), fr_w[k], 0);
            chk($sformatf("rst_vld%0d", k), fv_w[k], 0);
            chk($sformatf("rst_sq%0d", k), sq_w[k], 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NI; k++) begin
                exp_t e;
                if (fv_w[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("spurious_vld%0d", k), 1, 0);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("lat%0d", k), cyc, e.due);
                        chk($sformatf("freq%0d", k), fr_w[k], e.f);
                        chk($sformatf("sq%0d", k), sq_w[k], e.s);
                    end
                end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                    e = sb[k].pop_front();
                    chk($sformatf("missing_vld%0d", k), 0, 1);
                end
            end
        end
    end

    localparam logic [31:0] RAD_OK  = 32'h0001_0000;
    localparam logic [31:0] RAD_LOW = 32'h0000_0800;

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        do_reset();

        // Continuous ramp +0x01000000 per sample.
        for (int i = 0; i < 25; i++) send(32'(i) * 32'h0100_0000, RAD_OK);
        idle(LAT + 4);

        // Wrap across +180 deg, then the reverse direction.
        do_reset();
        send(32'h7F00_0000, RAD_OK);
        send(32'h8100_0000, RAD_OK);
        idle(LAT + 4);
        do_reset();
        send(32'h8100_0000, RAD_OK);
        send(32'h7F00_0000, RAD_OK);
        idle(LAT + 4);

        // Gapped strobe: one valid per 3 clocks, same ramp.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            send(32'(i) * 32'h0100_0000, RAD_OK);
            idle(2);
        end
        idle(LAT + 4);

        // Reset after 5 differences, with strobes still in flight.
        do_reset();
        for (int i = 0; i < 6; i++) send(32'(i) * 32'h0100_0000, RAD_OK);
        idle(3);
        do_reset();
        for (int i = 0; i < 9; i++) send(32'h4000_0000 + 32'(i) * 32'h0020_0000, RAD_OK);
        idle(LAT + 4);

        // Squelch: one low-radius sample inside the first 8-block.
        do_reset();
        for (int i = 0; i < 17; i++)
            send(32'(i) * 32'h0080_0000, (i == 4) ? RAD_LOW : RAD_OK);
        idle(LAT + 4);

        // Negative ramp -3, then alternating -1/-2 steps (floor rounding).
        do_reset();
        for (int i = 0; i < 17; i++) send(32'(-3 * i), RAD_OK);
        idle(LAT + 4);
        do_reset();
        begin
            logic [31:0] a;
            a = '0;
            for (int i = 0; i < 17; i++) begin
                send(a, RAD_OK);
                a = a - ((i % 2 == 0) ? 32'd1 : 32'd2);
            end
        end
        idle(LAT + 4);

        // Random angles and radii with random gaps.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send($urandom, ($urandom_range(0, 3) == 0) ? RAD_LOW : RAD_OK);
            idle($urandom_range(0, 3));
        end
        idle(LAT + 6);

        for (int k = 0; k < NI; k++) chk($sformatf("drain%0d", k), sb[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cordic_fm_discr.md
# cordic_fm_discr

Frequency discriminator placed directly downstream of the 32-cycle CORDIC atan/magnitude stage. Re-aligns the upstream sample strobe with the CORDIC's fixed latency and forms the phase difference between consecutive valid angle samples (instantaneous frequency). Accumulates and dumps the result over 2^DECIM_LOG2 samples, emitting one decimated frequency word per block with a one-cycle valid pulse. Optional magnitude squelch zeroes samples whose radius is below a programmable level.

## Interface
- LATENCY, 32, pipeline depth of the CORDIC stage in clocks; the in_valid delay line has exactly this many stages.
- DECIM_LOG2, 3, log2 of decimation factor; legal 0..8 (DECIM = 2^DECIM_LOG2).
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe, asserted in the same cycle IS/QS are presented to the CORDIC.
- angle  in  32 signed  CORDIC angle output; full scale ±2^31 = ±180°.
- coe_radius  in  32 unsigned  CORDIC radius output (unscaled by 1/K).
- sq_level  in  32 unsigned  squelch threshold; ignored when squelch is compiled out.
- freq  out  32 signed  decimated phase-difference average, same angle scaling as angle.
- freq_valid  out  1  one-cycle pulse, freq/squelch valid.
- squelch  out  1  at least one sample of the reported block was below sq_level.

## Operation
- v_al = in_valid delayed by LATENCY registers; angle/coe_radius are consumed only in cycles where v_al = 1.
- State: have_prev (1 b), prev_angle (32 b), acc (32+DECIM_LOG2 b signed), cnt (DECIM_LOG2 b), sq_seen (1 b).
- PRIME state (have_prev = 0): on v_al, prev_angle <= angle, have_prev <= 1; no difference formed, cnt unchanged.
- RUN state (have_prev = 1): on v_al, d = angle - prev_angle computed modulo 2^32 (32-bit wrap gives correct ±180° unwrapping, no saturation); prev_angle <= angle.
- If cnt != DECIM-1: acc <= acc + sext(d), cnt <= cnt + 1.
- If cnt == DECIM-1 (dump): freq <= (acc + sext(d)) >>> DECIM_LOG2 (arithmetic, rounds toward -inf, low 32 bits); freq_valid <= 1; squelch <= sq_seen | current-sample squelch; acc <= 0; cnt <= 0; sq_seen <= 0.
- DECIM_LOG2 = 0: every difference is dumped directly, freq = d.
- No v_al: all state holds; freq holds last value; freq_valid <= 0.
- Gaps in in_valid are allowed with any spacing; the block counts valid samples, not clocks.

## Timing
- Reset values: freq = 0, freq_valid = 0, squelch = 0; have_prev = 0, acc = 0, cnt = 0, sq_seen = 0, entire v_al delay line = 0.
- Reset mid-operation discards the partial block and all in-flight strobes; first output after reset needs 1 + DECIM new valid samples.
- Latency: freq_valid high LATENCY + 1 cycles after the in_valid of the block's last sample.
- Throughput: one sample per clock sustained; freq_valid can be high at most once per DECIM valid samples (never on consecutive cycles unless DECIM = 1).
- reset has priority over v_al in the same cycle.

## Configuration
- CORDIC_FM_SQUELCH_EN defined: per sample, if coe_radius < sq_level (unsigned) the difference d is replaced by 0 before accumulation and sq_seen is set; prev_angle still updates with the real angle; squelch output reports per block.
- Undefined: sq_level ignored, d always used, squelch output constant 0, sq_seen logic absent.

## Test plan
- DECIM_LOG2 = 3, in_valid continuous, angle ramps +0x01000000 per sample from 0 -> first freq_valid after 9th sample + LATENCY + 1 cycles, freq = 0x01000000, then every 8 samples.
- Wrap: prev angle 0x7F000000, next 0x81000000, DECIM_LOG2 = 0 -> freq = 0x02000000 (positive); reverse order -> freq = 0xFE000000.
- Gapped in_valid (one valid per 3 clocks) with same ramp as test 1 -> identical freq values, one freq_valid per 8 valid samples, pulse width 1 cycle.
- Reset asserted after 5 differences accumulated -> no freq_valid from that block; outputs 0; next freq_valid only after 9 further valid samples.
- Squelch enabled, sq_level = 0x1000, ramp +0x00800000, radius 0x0800 on one sample of an 8-block -> freq = 7*0x00800000 >>> 3 = 0x00700000, squelch = 1; next clean block squelch = 0.
- Negative average: angle ramp -3 per sample, DECIM_LOG2 = 1 -> freq = -3 (sum -6 >>> 1); ramp pattern -1, -2 -> sum -3 >>> 1 = -2 (floor).
